// File: rtl/hazard_sched_if.sv
// Signal bundle between the 5-stage pipeline and its hazard/sequencing unit.
// Data-memory handshake: an access is pending while mem_req=1 and completes on the cycle mem_ready=1.
interface hazard_sched_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_RegWrite;
    logic             id_MemRead;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             bubble_ex;
    logic             freeze;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_RegWrite, id_MemRead,
        output ex_branch_taken, mem_req, mem_ready,
        input  stall_if, stall_id, flush_id, bubble_ex, freeze, fwdA, fwdB, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_RegWrite, id_MemRead,
        input  ex_branch_taken, mem_req, mem_ready,
        output stall_if, stall_id, flush_id, bubble_ex, freeze, fwdA, fwdB, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_sched.sv
// Hazard unit for the RV32I 5-stage pipe: shadow scoreboard of EX/MEM/WB driving
// stall/flush/bubble controls, operand forwarding selects and saturating stall/flush counters.
module hazard_sched #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    hazard_sched_if.slave  hz
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic memwait, loaduse;
    logic stall_if, stall_id, flush_id, bubble_ex, freeze;
    logic [1:0] fwd_a, fwd_b;

    // MEM may only forward ALU results; a load's data is not available until WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input slot_t m, input slot_t w);
        if (m.valid && m.reg_write && !m.mem_read && m.rd != 5'd0 && m.rd == rs)
            return 2'b01;
        else if (w.valid && w.reg_write && w.rd != 5'd0 && w.rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        memwait = hz.mem_req & ~hz.mem_ready;
        loaduse = hz.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                  ((hz.id_use_rs1 & (hz.id_rs1 == ex_q.rd)) |
                   (hz.id_use_rs2 & (hz.id_rs2 == ex_q.rd)));
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        freeze    = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        ex_d      = ex_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        if (!rst) begin
            if (ex_q.valid) begin
                fwd_a = fwd_sel(ex_q.rs1, mem_q, wb_q);
                fwd_b = fwd_sel(ex_q.rs2, mem_q, wb_q);
            end
            if (memwait) begin
                // Whole pipe holds; a taken branch stays in EX and is acted on once the wait ends.
                freeze   = 1'b1;
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else begin
                mem_d = ex_q;
                wb_d  = mem_q;
                if (hz.ex_branch_taken) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    ex_d      = '0;
                end else if (loaduse) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    ex_d      = '0;
                end else begin
                    ex_d.valid     = hz.id_valid;
                    ex_d.rd        = hz.id_rd;
                    ex_d.reg_write = hz.id_RegWrite;
                    ex_d.mem_read  = hz.id_MemRead;
                    ex_d.rs1       = hz.id_rs1;
                    ex_d.rs2       = hz.id_rs2;
                end
            end
        end
        stall_cnt_d = (stall_if && !(&stall_cnt_q)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = (flush_id && !(&flush_cnt_q)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_if  = stall_if;
    assign hz.stall_id  = stall_id;
    assign hz.flush_id  = flush_id;
    assign hz.bubble_ex = bubble_ex;
    assign hz.freeze    = freeze;
    assign hz.fwdA      = fwd_a;
    assign hz.fwdB      = fwd_b;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule
